// File: rtl/csel_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Carry-select blocks are split evenly across STAGES register-separated stages.
module csel_addsub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NB  = WIDTH / BLOCK;
  localparam int unsigned BPS = NB / STAGES;

  // Runs BPS carry-select blocks starting at block 'first'; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] csel_blocks(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] part,
                                                 input logic             cin,
                                                 input int unsigned      first);
    logic [WIDTH-1:0] s;
    logic             c;
    logic [BLOCK:0]   r0;
    logic [BLOCK:0]   r1;
    int unsigned      lsb;
    s = part;
    c = cin;
    for (int unsigned k = 0; k < BPS; k++) begin
      lsb = (first + k) * BLOCK;
      r0 = {1'b0, a[lsb +: BLOCK]} + {1'b0, b[lsb +: BLOCK]};
      r1 = {1'b0, a[lsb +: BLOCK]} + {1'b0, b[lsb +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
      s[lsb +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
      c = c ? r1[BLOCK] : r0[BLOCK];
    end
    return {c, s};
  endfunction

  // Inputs seen by each stage: element 0 comes from the ports, element j from stage j-1.
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic              st_c   [STAGES];
  logic              st_sa  [STAGES];
  logic              st_sb  [STAGES];
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] adv;

  assign st_a[0]   = in_a;
  assign st_b[0]   = in_sub ? ~in_b : in_b;
  assign st_sum[0] = '0;
  assign st_c[0]   = in_sub | in_cin;
  assign st_sa[0]  = in_a[WIDTH-1];
  assign st_sb[0]  = st_b[0][WIDTH-1];
  assign st_v[0]   = in_valid;

  assign in_ready = adv[0];

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    logic [WIDTH:0] res;

    assign res = csel_blocks(st_a[j], st_b[j], st_sum[j], st_c[j], j * BPS);

    if (j < STAGES - 1) begin : g_mid
      logic             valid_q;
      logic [WIDTH-1:0] sum_q;
      logic             carry_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             sa_q;
      logic             sb_q;

      // A stalled stage keeps everything; an advancing one takes upstream valid as-is.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          carry_q <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
          sa_q    <= 1'b0;
          sb_q    <= 1'b0;
        end else if (adv[j]) begin
          valid_q <= st_v[j];
          if (st_v[j]) begin
            sum_q   <= res[WIDTH-1:0];
            carry_q <= res[WIDTH];
            a_q     <= st_a[j];
            b_q     <= st_b[j];
            sa_q    <= st_sa[j];
            sb_q    <= st_sb[j];
          end
        end
      end

      assign adv[j]      = !valid_q | adv[j+1];
      assign st_v[j+1]   = valid_q;
      assign st_sum[j+1] = sum_q;
      assign st_c[j+1]   = carry_q;
      assign st_a[j+1]   = a_q;
      assign st_b[j+1]   = b_q;
      assign st_sa[j+1]  = sa_q;
      assign st_sb[j+1]  = sb_q;
    end else begin : g_last
      logic ovf;
      logic zero;

      assign ovf  = (st_sa[j] == st_sb[j]) && (res[WIDTH-1] != st_sa[j]);
      assign zero = (res[WIDTH-1:0] == '0);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          out_sum   <= '0;
          out_cout  <= 1'b0;
          out_ovf   <= 1'b0;
          out_zero  <= 1'b0;
        end else if (adv[j]) begin
          out_valid <= st_v[j];
          if (st_v[j]) begin
            out_sum  <= res[WIDTH-1:0];
            out_cout <= res[WIDTH];
            out_ovf  <= ovf;
            out_zero <= zero;
          end
        end
      end

      assign adv[j] = !out_valid | out_ready;
    end
  end

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Directed bench for csel_addsub_pipe: single ops, streaming with backpressure, mid-flight reset.
module tb_csel_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  csel_addsub_pipe #(
    .WIDTH (32),
    .BLOCK (4),
    .STAGES(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain arithmetic reference, independent of the block structure.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic sub);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
    r.zero = (full[31:0] == 32'd0);
    return r;
  endfunction

  // Issues one op with out_ready high and checks the two-cycle latency and result fields.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [31:0] es,
                       input logic eco, input logic eov, input logic ez);
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_lat_early"}, out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, es);
    check({tag, "_cout"}, out_cout, eco);
    check({tag, "_ovf"}, out_ovf, eov);
    check({tag, "_zero"}, out_zero, ez);
  endtask

  initial begin
    res_t        expq[$];
    res_t        r;
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic        scin [8];
    logic        ssub [8];
    logic [31:0] hold_sum;
    logic        have_hold;
    logic        fin;
    logic        fout;
    int          sent;
    int          got;
    int          cnt;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_flags", {out_cout, out_ovf, out_zero}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    do_op("add_carry_cross", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
          32'h0001_0000, 1'b0, 1'b0, 1'b0);
    do_op("sub_min_one", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
          32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op("sub_equal", 32'd5, 32'd5, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    do_op("add_cin_wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    do_op("add_pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op("sub_borrow", 32'd1, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Streaming: 8 back-to-back ops, out_ready low in cycles 3-6.
    for (int i = 0; i < 8; i++) begin
      sa[i]   = $urandom;
      sb[i]   = $urandom;
      scin[i] = 1'($urandom_range(0, 1));
      ssub[i] = (i % 2 == 1);
    end
    sent      = 0;
    got       = 0;
    cnt       = 0;
    have_hold = 1'b0;
    hold_sum  = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a   = sa[sent];
        in_b   = sb[sent];
        in_cin = scin[sent];
        in_sub = ssub[sent];
      end
      #1;
      check("stream_in_ready", in_ready, (cnt < 2) || out_ready);
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("stream_extra", out_valid, 0);
        end else begin
          check("stream_sum", out_sum, expq[0].sum);
          check("stream_flags", {out_cout, out_ovf, out_zero},
                {expq[0].cout, expq[0].ovf, expq[0].zero});
        end
        if (!out_ready) begin
          if (have_hold) check("stall_hold", out_sum, hold_sum);
          hold_sum  = out_sum;
          have_hold = 1'b1;
        end else begin
          have_hold = 1'b0;
        end
      end
      if (fout && expq.size() > 0) begin
        void'(expq.pop_front());
        got++;
      end
      if (fin) begin
        expq.push_back(model(sa[sent], sb[sent], scin[sent], ssub[sent]));
        sent++;
      end
      cnt = cnt + int'(fin) - int'(fout);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stream_drained", got, 8);
    check("stream_sent", sent, 8);

    // Reset with two ops in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd1;
    in_b      = 32'd2;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    @(posedge clk);
    #1;
    in_a = 32'd10;
    in_b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("flight_valid", out_valid, 1);
    check("flight_sum", out_sum, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", out_sum, 0);
    check("midrst_flags", {out_cout, out_ovf, out_zero}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    r = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    do_op("post_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, r.sum, r.cout, r.ovf, r.zero);
    @(posedge clk);
    #1;
    check("post_reset_drain", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
